render_sequencer: RTL and testbench

- Parametrised frame-render sequencer for the game controller.
- Walks NUM_LAYERS object layers (tiles, explosions, bombs, players, HP icons, ...), each with a runtime item count, and issues one draw request per item to the blitter datapath.
- Waits for the frame tick, then requests a buffer-to-VGA present, and repeats.
- Replaces per-object hand-coded draw/update state pairs with a single indexed loop, and adds layer masking, zero-count skipping and tick buffering.

---
 rtl/render_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_render_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : render_sequencer
//  Description : Frame-render sequencer. Scans NUM_LAYERS object layers,
//                issues one draw request per item, waits for the frame tick
//                and then requests a buffer-to-VGA present. Disabled or empty
//                layers are skipped, and a tick seen while busy is remembered.
//                Optional lost-tick counter: define RENDER_SEQ_OVERRUN_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module render_sequencer #(
    parameter int NUM_LAYERS = 8,
    parameter int ID_W       = 6,
    parameter int CLK_DIV    = 833333,
    parameter int FRAME_DIV  = 15,
    localparam int c_lid_w   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       halt,
    input  logic [NUM_LAYERS-1:0]      layer_en,
    input  logic [NUM_LAYERS*ID_W-1:0] layer_count,
    input  logic                       draw_done,
    input  logic                       present_done,
    output logic                       draw_req,
    output logic [c_lid_w-1:0]         layer_id,
    output logic [ID_W-1:0]            item_id,
    output logic                       last_item,
    output logic                       present_req,
    output logic                       tick,
    output logic                       refresh,
    output logic                       busy,
    output logic [15:0]                frame_count,
    output logic [7:0]                 overrun_count
);

    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_ref_w = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_one    = c_div_w'(1);
    localparam logic [c_ref_w-1:0] c_ref_last   = c_ref_w'(FRAME_DIV - 1);
    localparam logic [c_ref_w-1:0] c_ref_one    = c_ref_w'(1);
    localparam logic [c_lid_w-1:0] c_last_layer = c_lid_w'(NUM_LAYERS - 1);
    localparam logic [c_lid_w-1:0] c_lid_one    = c_lid_w'(1);
    localparam logic [ID_W-1:0]    c_item_one   = ID_W'(1);
    localparam logic [ID_W:0]      c_item_inc   = (ID_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SCAN      = 3'd1,
        S_DRAW      = 3'd2,
        S_WAIT_TICK = 3'd3,
        S_PRESENT   = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_lid_w-1:0]   r_layer;
    logic [ID_W-1:0]      r_item;
    logic                 r_draw_req;
    logic                 r_present_req;
    logic                 r_busy;
    logic [15:0]          r_frame;
    logic [c_div_w-1:0]   r_div;
    logic [c_ref_w-1:0]   r_ref;
    logic                 r_pend;

    logic [ID_W-1:0]      w_counts [NUM_LAYERS];
    logic [ID_W-1:0]      w_cur_count;
    logic                 w_cur_en;
    logic [ID_W:0]        w_item_next;
    logic                 w_layer_skip;
    logic                 w_layer_end;
    logic                 w_last_layer;
    logic                 w_tick;
    logic                 w_enter_present;

    // Split the packed count bus into one count per layer
    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_unpack
        assign w_counts[k] = layer_count[k*ID_W +: ID_W];
    end

    assign w_cur_count  = w_counts[r_layer];
    assign w_cur_en     = layer_en[r_layer];
    assign w_item_next  = {1'b0, r_item} + c_item_inc;
    assign w_layer_skip = ~w_cur_en | (w_cur_count == '0);
    // Counts are live: a count shrunk below the current item still ends the layer
    assign w_layer_end  = (w_item_next >= {1'b0, w_cur_count});
    assign w_last_layer = (r_layer == c_last_layer);
    assign w_tick       = (r_div == c_div_last);
    assign w_enter_present = (r_state == S_WAIT_TICK) & (w_tick | r_pend);

    // Free-running frame tick divider
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_div_one;
        end
    end

    // Refresh divider advances once per tick
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ref <= '0;
        end else if (w_tick) begin
            r_ref <= (r_ref == c_ref_last) ? '0 : (r_ref + c_ref_one);
        end
    end

    // Remember a tick until PRESENT is entered; a tick on the entry cycle wins
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_tick | (r_pend & ~w_enter_present);
        end
    end

    // Sequencer FSM with registered request outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_layer       <= '0;
            r_item        <= '0;
            r_draw_req    <= 1'b0;
            r_present_req <= 1'b0;
            r_busy        <= 1'b0;
            r_frame       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SCAN;
                        r_layer <= '0;
                        r_item  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_layer_skip) begin
                        if (w_last_layer) begin
                            r_state <= S_WAIT_TICK;
                        end else begin
                            r_layer <= r_layer + c_lid_one;
                        end
                    end else begin
                        r_state    <= S_DRAW;
                        r_draw_req <= 1'b1;
                    end
                end
                S_DRAW: begin
                    if (draw_done) begin
                        if (w_layer_end) begin
                            r_item     <= '0;
                            r_draw_req <= 1'b0;
                            if (w_last_layer) begin
                                r_state <= S_WAIT_TICK;
                            end else begin
                                r_layer <= r_layer + c_lid_one;
                                r_state <= S_SCAN;
                            end
                        end else begin
                            r_item <= r_item + c_item_one;
                        end
                    end
                end
                S_WAIT_TICK: begin
                    if (w_tick | r_pend) begin
                        r_state       <= S_PRESENT;
                        r_present_req <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (present_done) begin
                        r_present_req <= 1'b0;
                        r_frame       <= r_frame + 16'd1;
                        r_layer       <= '0;
                        r_item        <= '0;
                        if (halt) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_layer       <= '0;
                    r_item        <= '0;
                    r_draw_req    <= 1'b0;
                    r_present_req <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef RENDER_SEQ_OVERRUN_EN
    logic [7:0] r_overrun;

    // Count ticks lost because one was already pending and not consumed
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overrun <= 8'd0;
        end else if (w_tick && r_pend && !w_enter_present && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    assign overrun_count = r_overrun;
`else
    assign overrun_count = 8'd0;
`endif

    assign draw_req    = r_draw_req;
    assign present_req = r_present_req;
    assign busy        = r_busy;
    assign layer_id    = r_layer;
    assign item_id     = r_item;
    assign last_item   = (w_item_next == {1'b0, w_cur_count});
    assign tick        = w_tick;
    assign refresh     = w_tick & (r_ref == c_ref_last);
    assign frame_count = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_render_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_render_sequencer
//  Description : Self-checking bench for render_sequencer with a draw-request
//                scoreboard and a tick / pending / overrun reference model.
//                Overrun expectation follows RENDER_SEQ_OVERRUN_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_render_sequencer;

    localparam int NL = 8;
    localparam int IW = 6;
    localparam int CD = 10;
    localparam int FD = 3;

    logic           clock = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic           halt = 1'b0;
    logic [NL-1:0]  layer_en = '0;
    logic [NL*IW-1:0] layer_count = '0;
    logic           draw_done = 1'b0;
    logic           present_done = 1'b0;
    logic           draw_req;
    logic [2:0]     layer_id;
    logic [IW-1:0]  item_id;
    logic           last_item;
    logic           present_req;
    logic           tick;
    logic           refresh;
    logic           busy;
    logic [15:0]    frame_count;
    logic [7:0]     overrun_count;

    render_sequencer #(
        .NUM_LAYERS (NL),
        .ID_W       (IW),
        .CLK_DIV    (CD),
        .FRAME_DIV  (FD)
    ) u_dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .halt          (halt),
        .layer_en      (layer_en),
        .layer_count   (layer_count),
        .draw_done     (draw_done),
        .present_done  (present_done),
        .draw_req      (draw_req),
        .layer_id      (layer_id),
        .item_id       (item_id),
        .last_item     (last_item),
        .present_req   (present_req),
        .tick          (tick),
        .refresh       (refresh),
        .busy          (busy),
        .frame_count   (frame_count),
        .overrun_count (overrun_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]    l;
        logic [IW-1:0] i;
        logic          last;
    } req_t;

    req_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_frames = 0;
    int   cyc;

    // Reference model state: pending tick and lost-tick count
    bit   m_pend = 1'b0;
    int   m_ovr = 0;
    bit   prev_tick = 1'b0;
    bit   prev_preq = 1'b0;
    bit   prev_valid = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Cycles since reset release; divider value equals cyc % CD at a negedge
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Tick, present gating and lost-tick model
    always @(negedge clock) begin
        bit entered;
        if (!resetn) begin
            m_pend     = 1'b0;
            m_ovr      = 0;
            prev_tick  = 1'b0;
            prev_preq  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            check_val("tick_mon", 32'(tick), 32'((cyc % CD) == CD - 1));
            if (prev_valid) begin
                entered = present_req && !prev_preq;
                if (entered) check_val("present_gate", 32'(prev_tick | m_pend), 32'd1);
                if (prev_tick && m_pend && !entered && m_ovr != 255) m_ovr++;
                m_pend = prev_tick ? 1'b1 : (entered ? 1'b0 : m_pend);
            end
            prev_tick  = ((cyc % CD) == CD - 1);
            prev_preq  = present_req;
            prev_valid = 1'b1;
        end
    end

    task automatic set_count(input int k, input int v);
        layer_count[k*IW +: IW] = IW'(v);
    endtask

    task automatic push_layer(input int l, input int cnt);
        req_t e;
        for (int i = 0; i < cnt; i++) begin
            e.l    = 3'(l);
            e.i    = IW'(i);
            e.last = (i == cnt - 1);
            exp_q.push_back(e);
        end
    endtask

    // One start pulse from IDLE; the following cycle must be SCAN at (0,0)
    task automatic kick();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_val("start_busy", 32'(busy), 32'd1);
        check_val("start_layer", 32'(layer_id), 32'd0);
        check_val("start_item", 32'(item_id), 32'd0);
        check_val("start_scan", 32'(draw_req), 32'd0);
    endtask

    // Serve draw requests with a fixed latency, then acknowledge one present
    task automatic serve_frame(input int budget, input int lat);
        int   dcnt;
        bit   got;
        req_t e;
        dcnt = 0;
        got  = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            draw_done = 1'b0;
            if (draw_req) begin
                if (dcnt == 0) begin
                    check_val("draw_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_val("draw_layer", 32'(layer_id), 32'(e.l));
                        check_val("draw_item", 32'(item_id), 32'(e.i));
                        check_val("draw_last", 32'(last_item), 32'(e.last));
                    end
                end
                if (dcnt == lat) begin
                    draw_done = 1'b1;
                    dcnt = 0;
                end else begin
                    dcnt++;
                end
            end else if (present_req) begin
                present_done = 1'b1;
                got = 1'b1;
                break;
            end
        end
        check_val("present_seen", 32'(got), 32'd1);
        @(negedge clock);
        present_done = 1'b0;
        draw_done    = 1'b0;
        if (got) exp_frames++;
        check_val("frame_count", 32'(frame_count), 32'(exp_frames));
        check_val("draws_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int exp_ovr;
        int pr_seen;
        bit found;

        // Reset state
        #12;
        check_val("rst_draw_req", 32'(draw_req), 32'd0);
        check_val("rst_present_req", 32'(present_req), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_frame", 32'(frame_count), 32'd0);
        check_val("rst_tick", 32'(tick), 32'd0);
        check_val("rst_refresh", 32'(refresh), 32'd0);
        check_val("rst_overrun", 32'(overrun_count), 32'd0);
        check_val("rst_layer", 32'(layer_id), 32'd0);
        check_val("rst_item", 32'(item_id), 32'd0);

        @(negedge clock);
        #2 resetn = 1'b1;

        // Tick on cycles 9,19,29; refresh only with the third tick
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            check_val("tick", 32'(tick), 32'((k % CD) == CD - 1));
            check_val("refresh", 32'(refresh), 32'(k == 29));
            check_val("idle_busy", 32'(busy), 32'd0);
        end

        // Masked layers: L0 and L2 drawn, L1/L3 counts nonzero but disabled
        layer_en = 8'b0000_0101;
        set_count(0, 2);
        set_count(1, 7);
        set_count(2, 3);
        set_count(3, 5);
        push_layer(0, 2);
        push_layer(2, 3);
        kick();
        serve_frame(300, 2);

        // All layers enabled but empty: straight to present
        layer_en    = '1;
        layer_count = '0;
        serve_frame(300, 2);

        // Halt sampled at present: back to IDLE, restart one cycle later
        layer_en = 8'b0000_0001;
        set_count(0, 1);
        push_layer(0, 1);
        halt = 1'b1;
        serve_frame(300, 1);
        check_val("halt_busy", 32'(busy), 32'd0);
        check_val("halt_present", 32'(present_req), 32'd0);
        halt = 1'b0;
        push_layer(0, 1);
        kick();
        serve_frame(300, 1);

        // Long draw: ticks pile up while drawing, exactly one present follows
        push_layer(0, 1);
        halt = 1'b1;
        serve_frame(300, 35);
`ifdef RENDER_SEQ_OVERRUN_EN
        exp_ovr = m_ovr;
`else
        exp_ovr = 0;
`endif
        check_val("overrun", 32'(overrun_count), 32'(exp_ovr));
        pr_seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clock);
            if (present_req) pr_seen++;
        end
        check_val("single_present", 32'(pr_seen), 32'd0);
        check_val("after_halt_busy", 32'(busy), 32'd0);
        halt = 1'b0;

        // Reset in the middle of drawing item (3,4)
        layer_en = 8'b0000_1000;
        layer_count = '0;
        set_count(3, 6);
        kick();
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            draw_done = 1'b0;
            if (draw_req) begin
                if (layer_id == 3'd3 && item_id == IW'(4)) begin
                    found = 1'b1;
                    break;
                end
                draw_done = 1'b1;
            end
        end
        check_val("reached_3_4", 32'(found), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check_val("arst_draw_req", 32'(draw_req), 32'd0);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_frame", 32'(frame_count), 32'd0);
        check_val("arst_layer", 32'(layer_id), 32'd0);
        check_val("arst_item", 32'(item_id), 32'd0);
        check_val("arst_overrun", 32'(overrun_count), 32'd0);
        draw_done = 1'b0;
        @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_val("post_rst_busy", 32'(busy), 32'd0);
        check_val("post_rst_draw", 32'(draw_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
